// File: rtl/tmec_decode_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmec_decode_serial_ctrl
// Purpose  : Load / Berlekamp-Massey iteration sequencer for the serial TMEC
//            BCH decoder datapath; tracks register length L and error count.
//            Optional freeze input enabled by macro TMEC_CTRL_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tmec_decode_serial_ctrl #(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        drnzero,
`ifdef TMEC_CTRL_STALL_EN
    input  logic                        stall,
`endif
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(2*T+2)-1:0]    err_cnt,
    output logic                        fail,
    output logic                        synpe,
    output logic                        snce,
    output logic                        bsel,
    output logic                        caLast,
    output logic                        cbBeg,
    output logic                        msmpe,
    output logic                        cce,
    output logic                        dringPe,
    output logic                        c0first
);

    localparam int c_KW = $clog2(M + 1);
    localparam int c_IW = $clog2(T);
    localparam int c_LW = $clog2(2 * T + 2);
    localparam logic [c_KW-1:0] c_KMAX = c_KW'(M);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_KW-1:0]   r_k, w_k_nxt;
    logic [c_IW-1:0]   r_i, w_i_nxt;
    logic [c_LW-1:0]   r_l, w_l_nxt;
    logic [c_LW-1:0]   r_err_cnt, w_err_nxt;
    logic              r_bsel, w_bsel_nxt;
    logic              r_fail, w_fail_nxt;
    logic              r_ready, r_busy, r_done;
    logic              w_ready_nxt, w_done_nxt;
    // {synpe, snce, caLast, cbBeg, msmpe, cce, dringPe, c0first}
    logic [7:0]        r_strb, w_strb_nxt;
    logic              w_stall, w_frozen;
    int                w_l_calc;

`ifdef TMEC_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_l_nxt     = r_l;
        w_bsel_nxt  = r_bsel;
        w_err_nxt   = r_err_cnt;
        w_fail_nxt  = r_fail;
        w_frozen    = w_stall && (r_state == S_LOAD || r_state == S_ITER);
        w_l_calc    = 2 * int'(r_i) + 1 - int'(r_l);
        if (w_l_calc > 2 * T + 1) begin
            w_l_calc = 2 * T + 1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                    w_i_nxt     = '0;
                    w_l_nxt     = '0;
                    w_bsel_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!w_frozen) begin
                    w_state_nxt = S_ITER;
                    w_k_nxt     = '0;
                    w_i_nxt     = '0;
                end
            end
            S_ITER: begin
                if (!w_frozen) begin
                    if (r_k == c_KMAX) begin
                        w_k_nxt = '0;
                        // Length change only when the discrepancy is nonzero and 2L <= 2i
                        if (drnzero && int'(r_l) <= int'(r_i)) begin
                            w_l_nxt    = w_l_calc[c_LW-1:0];
                            w_bsel_nxt = 1'b1;
                        end else begin
                            w_bsel_nxt = 1'b0;
                        end
                        if (int'(r_i) == T - 2) begin
                            w_state_nxt = S_DONE;
                            w_err_nxt   = w_l_nxt;
                            w_fail_nxt  = (int'(w_l_nxt) > T);
                        end else begin
                            w_i_nxt = r_i + 1'b1;
                        end
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave the flops glitch-free
        w_strb_nxt = '0;
        if (!w_frozen) begin
            if (w_state_nxt == S_LOAD) begin
                w_strb_nxt[7] = 1'b1;
                w_strb_nxt[6] = 1'b1;
            end else if (w_state_nxt == S_ITER) begin
                if (w_k_nxt == '0) begin
                    w_strb_nxt[4] = 1'b1;
                    w_strb_nxt[3] = 1'b1;
                    w_strb_nxt[1] = 1'b1;
                    w_strb_nxt[0] = 1'b1;
                end else if (w_k_nxt == c_KMAX) begin
                    w_strb_nxt[5] = 1'b1;
                end else begin
                    w_strb_nxt[2] = 1'b1;
                end
            end
        end
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_i       <= '0;
            r_l       <= '0;
            r_bsel    <= 1'b0;
            r_err_cnt <= '0;
            r_fail    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_strb    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_i       <= w_i_nxt;
            r_l       <= w_l_nxt;
            r_bsel    <= w_bsel_nxt;
            r_err_cnt <= w_err_nxt;
            r_fail    <= w_fail_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= !w_ready_nxt;
            r_done    <= w_done_nxt;
            r_strb    <= w_strb_nxt;
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = r_err_cnt;
    assign fail    = r_fail;
    assign bsel    = r_bsel;
    assign synpe   = r_strb[7];
    assign snce    = r_strb[6];
    assign caLast  = r_strb[5];
    assign cbBeg   = r_strb[4];
    assign msmpe   = r_strb[3];
    assign cce     = r_strb[2];
    assign dringPe = r_strb[1];
    assign c0first = r_strb[0];

endmodule
`default_nettype wire

// File: tb/tb_tmec_decode_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmec_decode_serial_ctrl
// Purpose  : Self-checking bench for tmec_decode_serial_ctrl (M=4, T=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmec_decode_serial_ctrl;

    localparam int M      = 4;
    localparam int T      = 3;
    localparam int LW     = $clog2(2 * T + 2);
    localparam int RUNLEN = 1 + (T - 1) * (M + 1);   // cycle index of done after accept

    logic clk = 1'b0;
    logic reset, start, drnzero, stall;
    logic ready, busy, done, fail, synpe, snce, bsel, caLast, cbBeg, msmpe, cce, dringPe, c0first;
    logic [LW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [T-2:0] dpat;
        int           err;
        logic         fl;
    } vec_t;

    always #5 clk = ~clk;

    tmec_decode_serial_ctrl #(.M(M), .T(T)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .drnzero (drnzero),
`ifdef TMEC_CTRL_STALL_EN
        .stall   (stall),
`endif
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .fail    (fail),
        .synpe   (synpe),
        .snce    (snce),
        .bsel    (bsel),
        .caLast  (caLast),
        .cbBeg   (cbBeg),
        .msmpe   (msmpe),
        .cce     (cce),
        .dringPe (dringPe),
        .c0first (c0first)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {ready, busy, done, synpe, snce, bsel, caLast, cbBeg, msmpe, cce, dringPe, c0first};
    endfunction

    // Expected output vector for cycle n after the accepting edge, from the cycle plan
    function automatic logic [11:0] exp_vec(input int n, input logic b);
        logic rdy, bsy, dn, sp, sc, cl, cb, ms, cc, dp, c0;
        int k;
        rdy = 0; bsy = 1; dn = 0; sp = 0; sc = 0; cl = 0; cb = 0; ms = 0; cc = 0; dp = 0; c0 = 0;
        if (n == 0) begin
            sp = 1; sc = 1;
        end else if (n < RUNLEN) begin
            k = (n - 1) % (M + 1);
            if (k == 0) begin
                cb = 1; ms = 1; dp = 1; c0 = 1;
            end else if (k == M) begin
                cl = 1;
            end else begin
                cc = 1;
            end
        end else if (n == RUNLEN) begin
            dn = 1;
        end else begin
            rdy = 1; bsy = 0;
        end
        return {rdy, bsy, dn, sp, sc, b, cl, cb, ms, cc, dp, c0};
    endfunction

    function automatic bit is_sample(input int n);
        return (n >= 1) && (n < RUNLEN) && ((n - 1) % (M + 1) == M);
    endfunction

    // One full run; drnzero is random outside the sampling cycles when noise=1
    task automatic do_run(input logic [T-2:0] dpat, input bit noise, output int got_err, output logic got_fail);
        int   l;
        int   it;
        logic b;
        l = 0; b = 0; got_err = -1; got_fail = 1'bx;
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n <= RUNLEN + 1; n++) begin
            it = (n - 1) / (M + 1);
            if (is_sample(n)) drnzero = dpat[it];
            else              drnzero = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            check($sformatf("vec_c%0d", n), 32'(obs()), 32'(exp_vec(n, b)));
            if (n == RUNLEN) begin
                check("err_cnt", 32'(err_cnt), 32'(l));
                check("fail", 32'(fail), 32'(l > T));
                got_err  = int'(err_cnt);
                got_fail = fail;
            end
            if (is_sample(n)) begin
                if (drnzero && l <= it) begin
                    l = 2 * it + 1 - l;
                    b = 1;
                end else begin
                    b = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        drnzero = 1'b0;
    endtask

    initial begin
        vec_t tbl[4];
        int   ge;
        logic gf;
        int   ndone, first_done, last_done;

        tbl[0] = '{dpat: 2'b00, err: 0, fl: 1'b0};
        tbl[1] = '{dpat: 2'b11, err: 2, fl: 1'b0};
        tbl[2] = '{dpat: 2'b10, err: 3, fl: 1'b0};
        tbl[3] = '{dpat: 2'b01, err: 1, fl: 1'b0};

        reset = 1'b1; start = 1'b0; drnzero = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vec", 32'(obs()), 32'h800);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_run(tbl[i].dpat, 1'b1, ge, gf);
            check($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].err));
            check($sformatf("tbl%0d_fail", i), 32'(gf), 32'(tbl[i].fl));
        end

        for (int r = 0; r < 12; r++) begin
            do_run(2'($urandom), 1'b1, ge, gf);
        end

        // Reset in the middle of iteration 1 after a run that left err_cnt=2
        do_run(2'b11, 1'b0, ge, gf);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_cce", 32'(cce), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_vec", 32'(obs()), 32'h800);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_fail", 32'(fail), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_run(2'b10, 1'b0, ge, gf);
        check("post_rst_err", 32'(ge), 32'd3);

        // start held high: back-to-back runs every 13 cycles
        @(negedge clk);
        start = 1'b1;
        ndone = 0; first_done = -1; last_done = -1;
        for (int j = 1; j <= 38; j++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) first_done = j;
                else check("b2b_period", 32'(j - last_done), 32'd13);
                last_done = j;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd3);
        check("b2b_first_done", 32'(first_done), 32'd12);
        repeat (2) @(negedge clk);
        check("b2b_idle_ready", 32'(ready), 32'd1);
        check("b2b_idle_busy", 32'(busy), 32'd0);

`ifdef TMEC_CTRL_STALL_EN
        begin
            int ncce, dcyc;
            ncce = 0; dcyc = -1;
            @(negedge clk);
            drnzero = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int n = 0; n < RUNLEN + 8; n++) begin
                stall = (n >= 2 && n <= 4);
                @(negedge clk);
                if (cce) ncce++;
                if (done && dcyc < 0) begin
                    dcyc = n;
                    check("stall_err_cnt", 32'(err_cnt), 32'd2);
                end
                @(posedge clk);
                #1;
            end
            stall = 1'b0;
            drnzero = 1'b0;
            check("stall_done_cycle", 32'(dcyc), 32'(RUNLEN + 3));
            check("stall_cce_count", 32'(ncce), 32'((T - 1) * (M - 1)));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
